// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor.
// Holds the FSM state encoding and a counter-width helper.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    // Bit counter width; a 1-bit counter is the floor for tiny widths.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell (combinational).
// Ports: a, b, bin in; d = a-b-bin bit, bout = borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per cycle.
// Ports: clk, rst (sync, active-high); in_valid/in_ready with a, b, bin;
// out_valid/out_ready with diff, bout (final borrow), ovf (signed overflow).
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [CW-1:0]    cnt;
    logic             borrow;
    logic             sign_a;
    logic             sign_b;
    logic             load;
    logic             step;
    logic             d_bit;
    logic             b_bit;

    full_subtractor u_fs (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (borrow),
        .d    (d_bit),
        .bout (b_bit)
    );

    // Handshake outputs depend on state only, never on in_valid/out_ready.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load     = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (cnt == LAST) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
        end else if (load) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            cnt    <= '0;
            borrow <= bin;
            sign_a <= a[WIDTH-1];
            sign_b <= b[WIDTH-1];
        end else if (step) begin
            a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
            // New bit enters at the MSB; after WIDTH steps bit 0 is the LSB.
            res_sr <= {d_bit, res_sr[WIDTH-1:1]};
            borrow <= b_bit;
            // Hold at LAST so the counter never wraps mid-operation.
            if (cnt != LAST) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign diff = res_sr;
    assign bout = borrow;
    assign ovf  = (sign_a ^ sign_b) & (res_sr[WIDTH-1] ^ sign_a);

endmodule
